// File: rtl/rand_blink_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// blink_pkg
// Shared definitions for the random blink sequencer and its timing helpers:
//   - state_t        : sequencer FSM state encoding
//   - WARMUP_CYCLES  : cycles spent waiting for the LFSR to load its seed
//   - clog2_min1()   : ceil(log2(n)) clamped to at least 1, for counter widths
// -----------------------------------------------------------------------------
package blink_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WARMUP = 3'd1,
        LOAD   = 3'd2,
        COUNT  = 3'd3,
        UPDATE = 3'd4
    } state_t;

    localparam int WARMUP_CYCLES = 2;

    // Width helper: a counter for n values never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        if (value <= 1) begin
            return 1;
        end else begin
            return $clog2(value);
        end
    endfunction

endpackage

// File: rtl/rand_blink_sequencer_if.sv
// -----------------------------------------------------------------------------
// rand_blink_sequencer_if
// Bundles the run request / LFSR word inputs and the LED / status outputs of
// the sequencer.
//   en, rand_in                          : driven by the master (control side)
//   lfsr_en, leds, update_pulse, lockup  : driven by the slave (sequencer)
// -----------------------------------------------------------------------------
interface rand_blink_sequencer_if #(
    parameter int RAND_WIDTH = 4,
    parameter int LED_COUNT  = 4
);
    logic                  en;
    logic [RAND_WIDTH-1:0] rand_in;
    logic                  lfsr_en;
    logic [LED_COUNT-1:0]  leds;
    logic                  update_pulse;
    logic                  lockup;

    modport master (
        output en,
        output rand_in,
        input  lfsr_en,
        input  leds,
        input  update_pulse,
        input  lockup
    );

    modport slave (
        input  en,
        input  rand_in,
        output lfsr_en,
        output leds,
        output update_pulse,
        output lockup
    );
endinterface

// File: rtl/rand_blink_sequencer_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running divide-by-PRESCALE counter producing a one-cycle tick on wrap.
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   clr  : synchronous clear of the count (has priority over run)
//   run  : advance the count this cycle
//   tick : high during the cycle in which the count wraps (run && count==PRESCALE-1)
// With PRESCALE=1 the wrap value is 0, so the register never leaves 0 and a
// tick is produced on every run cycle.
// -----------------------------------------------------------------------------
module tick_prescaler
    import blink_pkg::*;
#(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);
    localparam int PW = clog2_min1(PRESCALE);

    logic [PW-1:0] cnt_r;
    logic          at_wrap_s;

    assign at_wrap_s = (cnt_r == PW'(PRESCALE - 1));
    assign tick      = run & ~clr & at_wrap_s;

    // Prescale count: clear has priority, otherwise count up and wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {PW{1'b0}};
        end else if (clr) begin
            cnt_r <= {PW{1'b0}};
        end else if (run) begin
            if (at_wrap_s) begin
                cnt_r <= {PW{1'b0}};
            end else begin
                cnt_r <= cnt_r + PW'(1'b1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule

// File: rtl/rand_blink_sequencer.sv
// -----------------------------------------------------------------------------
// rand_blink_sequencer
// Consumer of the LFSR word. While running it keeps the LFSR enabled, samples
// a random word per blink to pick the interval (rand+MIN_UNITS units of
// PRESCALE clocks) and the LED to toggle, and flags the XNOR-LFSR all-ones
// lock-up after LOCK_LIMIT consecutive all-ones samples.
// Ports:
//   clk              : system clock
//   rst              : asynchronous, active-high reset
//   bus.en           : run request (level)
//   bus.rand_in      : LFSR output word
//   bus.lfsr_en      : LFSR enable, high in every state except IDLE (registered)
//   bus.leds         : LED drive (registered)
//   bus.update_pulse : one-cycle pulse on each LED toggle (registered)
//   bus.lockup       : sticky lock-up flag, cleared on rst or entry to IDLE
// -----------------------------------------------------------------------------
module rand_blink_sequencer
    import blink_pkg::*;
#(
    parameter int RAND_WIDTH = 4,
    parameter int LED_COUNT  = 4,
    parameter int PRESCALE   = 1000,
    parameter int MIN_UNITS  = 1,
    parameter int LOCK_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    rand_blink_sequencer_if.slave bus
);
    // Unit counter wide enough for the largest interval (all-ones + MIN_UNITS).
    localparam int UW = $clog2(2**RAND_WIDTH + MIN_UNITS) + 1;
    localparam int SW = clog2_min1(LED_COUNT);
    localparam int LW = clog2_min1(LOCK_LIMIT + 1);

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 wcnt_r;
    logic                 wcnt_nxt_s;
    logic [UW-1:0]        units_r;
    logic [UW-1:0]        units_nxt_s;
    logic [LW-1:0]        lock_cnt_r;
    logic [LW-1:0]        lock_cnt_nxt_s;
    logic [SW-1:0]        sel_r;
    logic [SW-1:0]        sel_nxt_s;
    logic [SW-1:0]        sel_src_s;
    logic [LED_COUNT-1:0] leds_r;
    logic [LED_COUNT-1:0] leds_nxt_s;
    logic                 pulse_r;
    logic                 pulse_nxt_s;
    logic                 lockup_r;
    logic                 lockup_nxt_s;
    logic                 lfsr_en_r;
    logic                 lfsr_en_nxt_s;
    logic                 pre_clr_s;
    logic                 pre_run_s;
    logic                 tick_s;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr_s),
        .run  (pre_run_s),
        .tick (tick_s)
    );

    // A single LED needs no selection; the index stays 0.
    generate
        if (LED_COUNT > 1) begin : g_sel_rand
            assign sel_src_s = bus.rand_in[SW-1:0];
        end else begin : g_sel_fixed
            assign sel_src_s = {SW{1'b0}};
        end
    endgenerate

    // Next-state and next-output logic for the blink sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        wcnt_nxt_s     = wcnt_r;
        units_nxt_s    = units_r;
        lock_cnt_nxt_s = lock_cnt_r;
        sel_nxt_s      = sel_r;
        leds_nxt_s     = leds_r;
        pulse_nxt_s    = 1'b0;
        lockup_nxt_s   = lockup_r;
        pre_clr_s      = 1'b0;
        pre_run_s      = 1'b0;

        if ((state_r != IDLE) && !bus.en) begin
            // Run request withdrawn: abandon the interval, drop any pending
            // toggle and return everything to the idle values.
            state_nxt_s    = IDLE;
            wcnt_nxt_s     = 1'b0;
            units_nxt_s    = {UW{1'b0}};
            lock_cnt_nxt_s = {LW{1'b0}};
            sel_nxt_s      = {SW{1'b0}};
            leds_nxt_s     = {LED_COUNT{1'b0}};
            lockup_nxt_s   = 1'b0;
            pre_clr_s      = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    wcnt_nxt_s     = 1'b0;
                    units_nxt_s    = {UW{1'b0}};
                    lock_cnt_nxt_s = {LW{1'b0}};
                    leds_nxt_s     = {LED_COUNT{1'b0}};
                    lockup_nxt_s   = 1'b0;
                    pre_clr_s      = 1'b1;
                    if (bus.en) begin
                        state_nxt_s = WARMUP;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end

                WARMUP: begin
                    // Gives the LFSR its seed-load cycle before the first sample.
                    if (wcnt_r == 1'(WARMUP_CYCLES - 1)) begin
                        wcnt_nxt_s  = 1'b0;
                        state_nxt_s = LOAD;
                    end else begin
                        wcnt_nxt_s  = wcnt_r + 1'b1;
                    end
                end

                LOAD: begin
                    units_nxt_s = UW'(bus.rand_in) + UW'(MIN_UNITS);
                    sel_nxt_s   = sel_src_s;
                    pre_clr_s   = 1'b1;
                    if (&bus.rand_in) begin
                        if (lock_cnt_r < LW'(LOCK_LIMIT)) begin
                            lock_cnt_nxt_s = lock_cnt_r + LW'(1'b1);
                        end else begin
                            lock_cnt_nxt_s = lock_cnt_r;
                        end
                    end else begin
                        lock_cnt_nxt_s = {LW{1'b0}};
                    end
                    // Set in the same LOAD in which the count reaches the limit.
                    if (lock_cnt_nxt_s >= LW'(LOCK_LIMIT)) begin
                        lockup_nxt_s = 1'b1;
                    end else begin
                        lockup_nxt_s = lockup_r;
                    end
                    state_nxt_s = COUNT;
                end

                COUNT: begin
                    pre_run_s = 1'b1;
                    if (tick_s) begin
                        if (units_r == UW'(1'b1)) begin
                            // Toggle and pulse are registered on the way into
                            // UPDATE so both are visible during that cycle.
                            state_nxt_s       = UPDATE;
                            leds_nxt_s[sel_r] = ~leds_r[sel_r];
                            pulse_nxt_s       = 1'b1;
                        end else begin
                            units_nxt_s = units_r - UW'(1'b1);
                        end
                    end else begin
                        units_nxt_s = units_r;
                    end
                end

                UPDATE: begin
                    state_nxt_s = LOAD;
                end

                default: begin
                    state_nxt_s = IDLE;
                    pre_clr_s   = 1'b1;
                end
            endcase
        end

        lfsr_en_nxt_s = (state_nxt_s != IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_r     <= 1'b0;
            units_r    <= {UW{1'b0}};
            lock_cnt_r <= {LW{1'b0}};
            sel_r      <= {SW{1'b0}};
            leds_r     <= {LED_COUNT{1'b0}};
            pulse_r    <= 1'b0;
            lockup_r   <= 1'b0;
            lfsr_en_r  <= 1'b0;
        end else begin
            wcnt_r     <= wcnt_nxt_s;
            units_r    <= units_nxt_s;
            lock_cnt_r <= lock_cnt_nxt_s;
            sel_r      <= sel_nxt_s;
            leds_r     <= leds_nxt_s;
            pulse_r    <= pulse_nxt_s;
            lockup_r   <= lockup_nxt_s;
            lfsr_en_r  <= lfsr_en_nxt_s;
        end
    end

    assign bus.lfsr_en      = lfsr_en_r;
    assign bus.leds         = leds_r;
    assign bus.update_pulse = pulse_r;
    assign bus.lockup       = lockup_r;
endmodule

// File: doc/rand_blink_sequencer.md
Name: rand_blink_sequencer

Overview:
Consumer stage directly downstream of the LFSR. It keeps the LFSR enabled while running and samples its pseudo-random word to choose a random blink interval. It times that interval with a prescaler plus a unit down-counter, then toggles one randomly selected LED. It also detects the XNOR-LFSR all-ones lock-up state and flags it to top-level status logic.

Parameters:
RAND_WIDTH, 4, width of the random word from the LFSR
LED_COUNT, 4, number of LEDs driven; power of two, at most 2**RAND_WIDTH
PRESCALE, 1000, clk cycles per interval unit; at least 1
MIN_UNITS, 1, constant added to the sampled value; at least 1, so the interval is never 0
LOCK_LIMIT, 3, consecutive all-ones samples that set lockup

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
en  input  1  run request, level-sensitive
rand_in  input  RAND_WIDTH  LFSR output word
lfsr_en  output  1  enable to LFSR; high in every state except IDLE
leds  output  LED_COUNT  LED drive, registered
update_pulse  output  1  one-cycle pulse on each LED toggle
lockup  output  1  sticky lock-up flag

Behaviour:
- Reset (async, rst=1): state=IDLE, lfsr_en=0, leds=0, update_pulse=0, lockup=0, prescaler=0, units=0, lock_cnt=0. All outputs are registered.
- FSM states: IDLE, WARMUP, LOAD, COUNT, UPDATE.
- IDLE: lfsr_en=0, leds=0. Moves to WARMUP on the edge where en=1.
- WARMUP: exactly 2 cycles; a 1-bit counter covers the LFSR seed-load cycle. Then goes to LOAD.
- LOAD (1 cycle):
  - units <= rand_in + MIN_UNITS, zero-extended to UW = $clog2(2**RAND_WIDTH + MIN_UNITS) + 1 bits.
  - prescaler <= 0.
  - Lock-up counting: if rand_in is all-ones, lock_cnt increments (saturating); otherwise lock_cnt <= 0.
  - When lock_cnt reaches LOCK_LIMIT, lockup <= 1.
  - Latch sel <= rand_in[$clog2(LED_COUNT)-1:0]. With LED_COUNT=1, sel is fixed at 0.
  - Next state: COUNT.
- COUNT:
  - Prescaler counts 0..PRESCALE-1 and wraps.
  - On each wrap, if units==1 go to UPDATE; otherwise units <= units-1.
  - COUNT therefore lasts exactly (rand+MIN_UNITS)*PRESCALE cycles.
- UPDATE (1 cycle): leds[sel] toggles and update_pulse=1, then back to LOAD.
  - Full period between update_pulse assertions: (rand+MIN_UNITS)*PRESCALE + 2 cycles.
- en=0 seen in any non-IDLE state: next edge goes to IDLE.
  - lfsr_en=0 and leds=0 at that edge; counters cleared.
  - Any pending UPDATE is dropped; update_pulse is not asserted.
- lockup is sticky. It clears only on rst or on entry to IDLE; lock_cnt also clears then.
- rst asserted mid-operation: every register takes its reset value immediately, without waiting for clk. Operation resumes via WARMUP once rst=0 and en=1.
- en held high from reset release: the first clk edge goes IDLE→WARMUP.
- PRESCALE=1: a prescaler tick occurs every cycle, and the prescaler register is a constant 0.

Decomposition:
- Shared package blink_pkg holds:
  - state enum typedef (IDLE, WARMUP, LOAD, COUNT, UPDATE);
  - function clog2_min1 (returns at least 1);
  - localparam WARMUP_CYCLES=2.
- One natural sub-module: tick_prescaler.
  - Parameter PRESCALE; ports clk, rst, clr, run, tick.
  - tick is a one-cycle pulse on wrap.
  - Reused by other timing blocks in the design.

Test Plan (PRESCALE=4, MIN_UNITS=1 unless noted):
1. Reset: rst=1 pulsed asynchronously between clk edges → all outputs 0 immediately, before the next edge.
2. First interval: en=1, rand_in=5 held → lfsr_en=1 after 1 edge. LOAD occurs on cycle 3 after en, then COUNT lasts 24 cycles. update_pulse is high for one cycle and leds=4'b0010 (sel=5[1:0]=1).
3. Random index and period: rand_in sequence 2,3,2 sampled at successive LOADs → leds goes 0100, 1100, 1000. Gaps between update_pulse are 14, 18, 14 cycles.
4. Disable mid-COUNT: drop en 10 cycles into COUNT → next edge gives lfsr_en=0 and leds=0, with no update_pulse. Re-raising en restarts from WARMUP.
5. Lock-up: rand_in=4'hF held → lockup=1 after the 3rd LOAD. It stays 1 across later LOADs with rand_in=0 and clears on en=0.
6. Boundaries: PRESCALE=1, MIN_UNITS=1, rand_in=0 → update_pulse every 3 cycles. rand_in=4'hF (LOCK_LIMIT raised) → units=16 with no overflow; period is 18 cycles.
